// File: rtl/int_queue_select.sv
// rtl/int_queue_select.sv - integer issue-queue select stage with one-entry output buffer
// Define ISSUE_AGE_SELECT_EN to grant the oldest ready entry; otherwise the lowest index wins.
module int_queue_select #(
   parameter int QUEUE_SIZE = 8,
   parameter int IDX_W      = 3,
   parameter int AL_W       = 6,
   parameter int PAYLOAD_W  = 96
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [QUEUE_SIZE-1:0]         q_occupied,
   input  logic [QUEUE_SIZE-1:0]         q_ready1,
   input  logic [QUEUE_SIZE-1:0]         q_ready2,
   input  logic [QUEUE_SIZE*AL_W-1:0]    q_al_id,
   input  logic [QUEUE_SIZE*PAYLOAD_W-1:0] q_payload,
   input  logic [AL_W-1:0]               al_head,
   input  logic                          flush_valid,
   input  logic [AL_W-1:0]               flush_id,
   output logic [QUEUE_SIZE-1:0]         free_mask,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [IDX_W-1:0]              out_idx,
   output logic [AL_W-1:0]               out_al_id,
   output logic [PAYLOAD_W-1:0]          out_payload
);

   logic [AL_W-1:0]      id_arr  [QUEUE_SIZE];
   logic [AL_W-1:0]      age_arr [QUEUE_SIZE];
   logic [PAYLOAD_W-1:0] pl_arr  [QUEUE_SIZE];
   logic [AL_W-1:0]      flush_age;
   logic [AL_W-1:0]      out_age;
   logic [QUEUE_SIZE-1:0] squash;
   logic [QUEUE_SIZE-1:0] cand;
   logic [QUEUE_SIZE-1:0] grant;
   logic                  any_cand;
   logic [IDX_W-1:0]      sel_idx;
   logic                  load_en;

   logic                 out_valid_q, out_valid_d;
   logic [IDX_W-1:0]     out_idx_q, out_idx_d;
   logic [AL_W-1:0]      out_al_id_q, out_al_id_d;
   logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;

   // Ages are relative to the active-list head so id wrap-around orders correctly.
   always_comb begin
      flush_age = flush_id - al_head;
      out_age   = out_al_id_q - al_head;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         id_arr[i]  = q_al_id[i*AL_W +: AL_W];
         pl_arr[i]  = q_payload[i*PAYLOAD_W +: PAYLOAD_W];
         age_arr[i] = id_arr[i] - al_head;
         squash[i]  = flush_valid & q_occupied[i] & (age_arr[i] > flush_age);
         cand[i]    = q_occupied[i] & q_ready1[i] & q_ready2[i] & ~squash[i];
      end
   end

`ifdef ISSUE_AGE_SELECT_EN
   // Heap-ordered comparator tree: leaves at QUEUE_SIZE+i, winner at node 1.
   logic                 t_vld [1:2*QUEUE_SIZE-1];
   logic [AL_W-1:0]      t_age [1:2*QUEUE_SIZE-1];
   logic [IDX_W-1:0]     t_idx [1:2*QUEUE_SIZE-1];

   always_comb begin
      for (int n = 0; n < QUEUE_SIZE; n++) begin
         t_vld[QUEUE_SIZE+n] = cand[n];
         t_age[QUEUE_SIZE+n] = age_arr[n];
         t_idx[QUEUE_SIZE+n] = IDX_W'(n);
      end
      for (int n = QUEUE_SIZE-1; n >= 1; n--) begin
         if (t_vld[2*n] && (!t_vld[2*n+1] || (t_age[2*n] < t_age[2*n+1]))) begin
            t_vld[n] = t_vld[2*n];
            t_age[n] = t_age[2*n];
            t_idx[n] = t_idx[2*n];
         end else begin
            t_vld[n] = t_vld[2*n+1];
            t_age[n] = t_age[2*n+1];
            t_idx[n] = t_idx[2*n+1];
         end
      end
      any_cand = t_vld[1];
      sel_idx  = t_idx[1];
   end
`else
   always_comb begin
      any_cand = 1'b0;
      sel_idx  = '0;
      for (int i = QUEUE_SIZE-1; i >= 0; i--) begin
         if (cand[i]) begin
            any_cand = 1'b1;
            sel_idx  = IDX_W'(i);
         end
      end
   end
`endif

   always_comb begin
      load_en = ~out_valid_q | out_ready;
      grant   = '0;
      if (load_en && any_cand) begin
         grant[sel_idx] = 1'b1;
      end
      free_mask = grant | squash;
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      out_idx_d     = out_idx_q;
      out_al_id_d   = out_al_id_q;
      out_payload_d = out_payload_q;
      if (load_en) begin
         out_valid_d   = any_cand;
         out_idx_d     = sel_idx;
         out_al_id_d   = id_arr[sel_idx];
         out_payload_d = pl_arr[sel_idx];
      end else if (flush_valid && (out_age > flush_age)) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         out_idx_q     <= '0;
         out_al_id_q   <= '0;
         out_payload_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_idx_q     <= out_idx_d;
         out_al_id_q   <= out_al_id_d;
         out_payload_q <= out_payload_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_idx     = out_idx_q;
   assign out_al_id   = out_al_id_q;
   assign out_payload = out_payload_q;

endmodule

// File: tb/tb_int_queue_select.sv
// tb/tb_int_queue_select.sv - directed-vector bench for int_queue_select
// Expectations follow ISSUE_AGE_SELECT_EN when the bench is built with it defined.
module tb_int_queue_select;

   logic         clk;
   logic         rst_n;
   logic [7:0]   q_occupied;
   logic [7:0]   q_ready1;
   logic [7:0]   q_ready2;
   logic [47:0]  q_al_id;
   logic [767:0] q_payload;
   logic [5:0]   al_head;
   logic         flush_valid;
   logic [5:0]   flush_id;
   logic [7:0]   free_mask;
   logic         out_valid;
   logic         out_ready;
   logic [2:0]   out_idx;
   logic [5:0]   out_al_id;
   logic [95:0]  out_payload;

   int vectors;
   int miscompares;

   int          exp_idx;
   logic [5:0]  exp_id;
   logic [7:0]  exp_mask;

   int_queue_select dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .q_occupied  (q_occupied),
      .q_ready1    (q_ready1),
      .q_ready2    (q_ready2),
      .q_al_id     (q_al_id),
      .q_payload   (q_payload),
      .al_head     (al_head),
      .flush_valid (flush_valid),
      .flush_id    (flush_id),
      .free_mask   (free_mask),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_idx     (out_idx),
      .out_al_id   (out_al_id),
      .out_payload (out_payload)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [95:0] pl(input int s);
      return {32'hCAFE_0000 | 32'(s), 64'h0123_4567_89AB_CDEF ^ 64'(s)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_occupied = '0;
      q_ready1   = '0;
      q_ready2   = '0;
      q_al_id    = '0;
      q_payload  = '0;
   endtask

   task automatic set_entry(input int s, input logic [5:0] id, input logic rdy);
      q_occupied[s]          = 1'b1;
      q_ready1[s]            = rdy;
      q_ready2[s]            = rdy;
      q_al_id[s*6 +: 6]      = id;
      q_payload[s*96 +: 96]  = pl(s);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", out_valid); end
      vectors++; if (out_idx !== 3'd0) begin miscompares++; $display("FAIL reset_idx got %0d want 0", out_idx); end
      vectors++; if (out_al_id !== 6'd0) begin miscompares++; $display("FAIL reset_al_id got %0d want 0", out_al_id); end
      vectors++; if (out_payload !== 96'd0) begin miscompares++; $display("FAIL reset_payload got %h want 0", out_payload); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      clear_q();
      al_head   = 6'd0;
      out_ready = 1'b1;
      set_entry(5, 6'd3, 1'b1);
      #1;
      vectors++; if (free_mask !== 8'h20) begin miscompares++; $display("FAIL single_free got %h want 20", free_mask); end
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %0b want 1", out_valid); end
      vectors++; if (out_idx !== 3'd5) begin miscompares++; $display("FAIL single_idx got %0d want 5", out_idx); end
      vectors++; if (out_al_id !== 6'd3) begin miscompares++; $display("FAIL single_al_id got %0d want 3", out_al_id); end
      vectors++; if (out_payload !== pl(5)) begin miscompares++; $display("FAIL single_payload got %h want %h", out_payload, pl(5)); end
      clear_q();
      #1;
      vectors++; if (free_mask !== 8'h00) begin miscompares++; $display("FAIL single_empty_free got %h want 00", free_mask); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain_valid got %0b want 0", out_valid); end
   endtask

   task automatic test_age_vs_index();
      clear_q();
      al_head = 6'd0;
      set_entry(1, 6'd10, 1'b1);
      set_entry(6, 6'd2, 1'b1);
`ifdef ISSUE_AGE_SELECT_EN
      exp_idx = 6; exp_id = 6'd2; exp_mask = 8'h40;
`else
      exp_idx = 1; exp_id = 6'd10; exp_mask = 8'h02;
`endif
      #1;
      vectors++; if (free_mask !== exp_mask) begin miscompares++; $display("FAIL age_free got %h want %h", free_mask, exp_mask); end
      tick();
      vectors++; if (out_idx !== 3'(exp_idx)) begin miscompares++; $display("FAIL age_idx got %0d want %0d", out_idx, exp_idx); end
      vectors++; if (out_al_id !== exp_id) begin miscompares++; $display("FAIL age_al_id got %0d want %0d", out_al_id, exp_id); end
   endtask

   task automatic test_wrap();
      clear_q();
      al_head = 6'd60;
      set_entry(0, 6'd1, 1'b1);
      set_entry(2, 6'd62, 1'b1);
`ifdef ISSUE_AGE_SELECT_EN
      exp_idx = 2; exp_id = 6'd62; exp_mask = 8'h04;
`else
      exp_idx = 0; exp_id = 6'd1; exp_mask = 8'h01;
`endif
      #1;
      vectors++; if (free_mask !== exp_mask) begin miscompares++; $display("FAIL wrap_free got %h want %h", free_mask, exp_mask); end
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got %0b want 1", out_valid); end
      vectors++; if (out_idx !== 3'(exp_idx)) begin miscompares++; $display("FAIL wrap_idx got %0d want %0d", out_idx, exp_idx); end
   endtask

   task automatic test_back_to_back();
      int order [3];
      order[0] = 0; order[1] = 3; order[2] = 7;
      // Buffer still holds the wrap-test op; stall it.
      out_ready = 1'b0;
      clear_q();
      al_head = 6'd0;
      set_entry(0, 6'd10, 1'b1);
      set_entry(3, 6'd11, 1'b1);
      set_entry(7, 6'd12, 1'b1);
      for (int c = 0; c < 4; c++) begin
         #1;
         vectors++; if (free_mask !== 8'h00) begin miscompares++; $display("FAIL stall_free c%0d got %h want 00", c, free_mask); end
         tick();
         vectors++; if (out_valid !== 1'b1 || out_al_id !== exp_id) begin miscompares++; $display("FAIL stall_hold c%0d got v%0b id%0d want v1 id%0d", c, out_valid, out_al_id, exp_id); end
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++; if (free_mask !== (8'h01 << order[k])) begin miscompares++; $display("FAIL drain_free k%0d got %h want %h", k, free_mask, 8'h01 << order[k]); end
         tick();
         vectors++; if (out_valid !== 1'b1 || out_idx !== 3'(order[k])) begin miscompares++; $display("FAIL drain_idx k%0d got v%0b idx%0d want v1 idx%0d", k, out_valid, out_idx, order[k]); end
         q_occupied[order[k]] = 1'b0;
         q_ready1[order[k]]   = 1'b0;
         q_ready2[order[k]]   = 1'b0;
      end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_end_valid got %0b want 0", out_valid); end
   endtask

   task automatic test_flush();
      clear_q();
      al_head   = 6'd0;
      out_ready = 1'b1;
      set_entry(4, 6'd9, 1'b1);
      tick();
      vectors++; if (out_valid !== 1'b1 || out_al_id !== 6'd9) begin miscompares++; $display("FAIL flush_setup got v%0b id%0d want v1 id9", out_valid, out_al_id); end
      clear_q();
      out_ready = 1'b0;
      set_entry(1, 6'd3, 1'b0);
      set_entry(2, 6'd4, 1'b0);
      set_entry(5, 6'd7, 1'b0);
      flush_valid = 1'b1;
      flush_id    = 6'd4;
      #1;
      vectors++; if (free_mask !== 8'h20) begin miscompares++; $display("FAIL flush_free got %h want 20", free_mask); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %0b want 0", out_valid); end
      flush_valid = 1'b0;
      q_occupied[5] = 1'b0;
      #1;
      vectors++; if (free_mask !== 8'h00) begin miscompares++; $display("FAIL flush_survivors_free got %h want 00", free_mask); end
      q_ready1[1] = 1'b1; q_ready2[1] = 1'b1;
      q_ready1[2] = 1'b1; q_ready2[2] = 1'b1;
      #1;
      vectors++; if (free_mask !== 8'h02) begin miscompares++; $display("FAIL flush_regrant_free got %h want 02", free_mask); end
      tick();
      vectors++; if (out_idx !== 3'd1 || out_al_id !== 6'd3) begin miscompares++; $display("FAIL flush_regrant got idx%0d id%0d want idx1 id3", out_idx, out_al_id); end
   endtask

   task automatic test_mid_reset();
      clear_q();
      out_ready = 1'b0;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_valid got %0b want 1", out_valid); end
      rst_n = 1'b0;
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
      vectors++; if (out_idx !== 3'd0 || out_al_id !== 6'd0) begin miscompares++; $display("FAIL midrst_fields got idx%0d id%0d want 0 0", out_idx, out_al_id); end
      vectors++; if (out_payload !== 96'd0) begin miscompares++; $display("FAIL midrst_payload got %h want 0", out_payload); end
      rst_n = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      out_ready   = 1'b0;
      al_head     = '0;
      flush_valid = 1'b0;
      flush_id    = '0;
      clear_q();
      test_reset();
      test_single();
      test_age_vs_index();
      test_wrap();
      test_back_to_back();
      test_flush();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
